// File: rtl/pulse_spacer_pkg.sv
// -----------------------------------------------------------------------------
// pulse_spacer_pkg
//
// Purpose : Shared definitions for the pulse_spacer block and its per-channel
//           sub-module. It holds the per-channel FSM encoding, the counter width
//           constants and a small saturating-increment helper.
//
// Contents:
//   state_e      - per-channel FSM state (ST_IDLE = 1'b0, ST_GAP = 1'b1)
//   GAP_CNT_W    - width of the per-channel gap counter (8)
//   DROP_CNT_W   - width of the per-channel dropped-event counter (8)
//   drop_sat_inc - increment that holds at all-ones instead of wrapping
// -----------------------------------------------------------------------------
package pulse_spacer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  localparam int GAP_CNT_W  = 8;
  localparam int DROP_CNT_W = 8;

  // Saturating +1 for the dropped-event counter.
  function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(
    input logic [DROP_CNT_W-1:0] v
  );
    logic [DROP_CNT_W-1:0] r;
    r = (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
    return r;
  endfunction

endpackage : pulse_spacer_pkg

// File: rtl/pulse_spacer_chnl.sv
// -----------------------------------------------------------------------------
// pulse_spacer_chnl
//
// Purpose : One independent channel of the pulse spacer. Incoming single-cycle
//           events are re-emitted with at least P_MIN_GAP idle cycles between
//           consecutive output pulses. Events that arrive while the channel is
//           busy are counted in pend_cnt. Events that arrive when pend_cnt is
//           full are dropped and raise a sticky overflow flag.
//
// Optional: When PULSE_SPACER_DROP_CNT_EN is defined, an 8-bit saturating count
//           of dropped events is also provided on drop_cnt_oh.
//
// Ports   :
//   clk_ir      in   source-domain clock
//   rst_il      in   asynchronous active-low reset
//   pulse_ih    in   single-cycle event pulse
//   ovf_clr_ih  in   single-cycle clear of the overflow flag (and drop count)
//   pulse_oh    out  spaced single-cycle output pulse (registered)
//   pend_oh     out  high while events are queued or the gap window is open
//   ovf_oh      out  sticky overflow flag
//   drop_cnt_oh out  saturating dropped-event count (PULSE_SPACER_DROP_CNT_EN only)
// -----------------------------------------------------------------------------
module pulse_spacer_chnl
  import pulse_spacer_pkg::*;
#(
  parameter int P_MIN_GAP = 4,
  parameter int P_CNT_W   = 4
) (
  input  logic clk_ir,
  input  logic rst_il,
  input  logic pulse_ih,
  input  logic ovf_clr_ih,
  output logic pulse_oh,
  output logic pend_oh,
  output logic ovf_oh
`ifdef PULSE_SPACER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt_oh
`endif
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(P_MIN_GAP);
  localparam logic [P_CNT_W-1:0]   PEND_MAX = {P_CNT_W{1'b1}};
  localparam logic [P_CNT_W-1:0]   PEND_ONE = P_CNT_W'(1);

  state_e                 state_q,   state_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [P_CNT_W-1:0]     pend_cnt_q, pend_cnt_d;
  logic                   pulse_q,   pulse_d;
  logic                   pend_q,    pend_d;
  logic                   ovf_q,     ovf_d;

  logic                   pend_nz;
  logic                   issue_queued;
  logic                   bypass;
  logic                   inc;
  logic                   dec;
  logic                   drop;

  // Next-state: FSM, gap counter and output pulse
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    pulse_d      = 1'b0;
    issue_queued = 1'b0;
    bypass       = 1'b0;
    pend_nz      = (pend_cnt_q != '0);

    case (state_q)
      ST_IDLE: begin
        if (pulse_ih || pend_nz) begin
          pulse_d   = 1'b1;
          gap_cnt_d = GAP_LOAD;
          state_d   = ST_GAP;
          // A queued event has priority for the slot. The new pulse (if any)
          // is then counted instead. This keeps the inc/dec pair balanced.
          issue_queued = pend_nz;
          bypass       = pulse_ih & ~pend_nz;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
        if (gap_cnt_q == GAP_CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next-state: pending counter, overflow flag and pending indicator
  always_comb begin
    inc        = pulse_ih & ~bypass;
    dec        = issue_queued;
    drop       = inc & ~dec & (pend_cnt_q == PEND_MAX);
    pend_cnt_d = pend_cnt_q;

    if (inc && !dec && !drop) begin
      pend_cnt_d = pend_cnt_q + PEND_ONE;
    end else if (dec && !inc) begin
      pend_cnt_d = pend_cnt_q - PEND_ONE;
    end

    // A drop on the same cycle as a clear keeps the flag set.
    ovf_d = drop | (ovf_q & ~ovf_clr_ih);

    // The gap window is the emitted-pulse cycle plus the following P_MIN_GAP
    // idle cycles. GAP covers all of them except the last one, and state_q
    // extends the window by one cycle to cover it.
    pend_d = (pend_cnt_d != '0) | (state_d == ST_GAP) |
             (state_q == ST_GAP) | pulse_d;
  end

  // Register stage
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      pend_cnt_q <= '0;
      pulse_q    <= 1'b0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      pend_cnt_q <= pend_cnt_d;
      pulse_q    <= pulse_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pulse_oh = pulse_q;
  assign pend_oh  = pend_q;
  assign ovf_oh   = ovf_q;

`ifdef PULSE_SPACER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // A clear coinciding with a drop leaves that drop counted.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr_ih) begin
      drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      drop_cnt_d = drop_sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_oh = drop_cnt_q;
`endif

endmodule : pulse_spacer_chnl

// File: rtl/pulse_spacer.sv
// -----------------------------------------------------------------------------
// pulse_spacer
//
// Purpose : Sits upstream of the toggle pulse synchronizer in the source clock
//           domain. It accepts bursty single-cycle events on P_NO_OF_PULSES
//           independent channels and queues them per channel. It re-emits them
//           with at least P_MIN_GAP idle cycles between pulses of the same
//           channel, so the slower destination sampler never loses a toggle.
//           Events dropped because a channel queue is full raise a sticky
//           per-channel overflow flag.
//
// Optional: Define PULSE_SPACER_DROP_CNT_EN to add drop_cnt_oh. It holds an
//           8-bit saturating dropped-event count per channel; channel i is at
//           bits [i*8+7:i*8].
//
// Parameters:
//   P_NO_OF_PULSES  number of independent channels
//   P_MIN_GAP       idle cycles between emitted pulses of a channel (1..255)
//   P_CNT_W         pending-counter width; up to 2^P_CNT_W-1 queued events
//
// Ports   :
//   clk_ir      in   source-domain clock
//   rst_il      in   asynchronous active-low reset
//   pulse_ih    in   [P_NO_OF_PULSES] single-cycle event pulses
//   pulse_oh    out  [P_NO_OF_PULSES] spaced single-cycle pulses
//   pend_oh     out  [P_NO_OF_PULSES] queued events or gap window open
//   ovf_oh      out  [P_NO_OF_PULSES] sticky overflow flags
//   ovf_clr_ih  in   clears all overflow flags (and drop counts)
//   drop_cnt_oh out  [P_NO_OF_PULSES*8] dropped-event counts (optional)
// -----------------------------------------------------------------------------
module pulse_spacer
  import pulse_spacer_pkg::*;
#(
  parameter int P_NO_OF_PULSES = 2,
  parameter int P_MIN_GAP      = 4,
  parameter int P_CNT_W        = 4
) (
  input  logic                      clk_ir,
  input  logic                      rst_il,
  input  logic [P_NO_OF_PULSES-1:0] pulse_ih,
  output logic [P_NO_OF_PULSES-1:0] pulse_oh,
  output logic [P_NO_OF_PULSES-1:0] pend_oh,
  output logic [P_NO_OF_PULSES-1:0] ovf_oh,
  input  logic                      ovf_clr_ih
`ifdef PULSE_SPACER_DROP_CNT_EN
  ,
  output logic [P_NO_OF_PULSES*DROP_CNT_W-1:0] drop_cnt_oh
`endif
);

  // Channels are fully independent; ovf_clr_ih fans out to every channel.
  for (genvar i = 0; i < P_NO_OF_PULSES; i++) begin : g_chnl
    pulse_spacer_chnl #(
      .P_MIN_GAP (P_MIN_GAP),
      .P_CNT_W   (P_CNT_W)
    ) u_chnl (
      .clk_ir      (clk_ir),
      .rst_il      (rst_il),
      .pulse_ih    (pulse_ih[i]),
      .ovf_clr_ih  (ovf_clr_ih),
      .pulse_oh    (pulse_oh[i]),
      .pend_oh     (pend_oh[i]),
      .ovf_oh      (ovf_oh[i])
`ifdef PULSE_SPACER_DROP_CNT_EN
      ,
      .drop_cnt_oh (drop_cnt_oh[i*DROP_CNT_W +: DROP_CNT_W])
`endif
    );
  end

endmodule : pulse_spacer

// File: tb/tb_pulse_spacer.sv
// -----------------------------------------------------------------------------
// tb_pulse_spacer
//
// Scoreboard bench for pulse_spacer. After each clock edge, the driver applies
// the inputs for the coming edge. A cooldown/queue-count reference model then
// pushes the outputs expected after that edge. A monitor on the falling edge
// pops those expectations and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pulse_spacer;

  localparam int N    = 2;
  localparam int GAP  = 4;
  localparam int CW   = 3;
  localparam int PMAX = (1 << CW) - 1;

  logic         clk_ir     = 1'b0;
  logic         rst_il     = 1'b0;
  logic [N-1:0] pulse_ih   = '0;
  logic         ovf_clr_ih = 1'b0;
  logic [N-1:0] pulse_oh;
  logic [N-1:0] pend_oh;
  logic [N-1:0] ovf_oh;
`ifdef PULSE_SPACER_DROP_CNT_EN
  logic [N*8-1:0] drop_cnt_oh;
`endif

  always #5 clk_ir = ~clk_ir;

  pulse_spacer #(
    .P_NO_OF_PULSES (N),
    .P_MIN_GAP      (GAP),
    .P_CNT_W        (CW)
  ) dut (
    .clk_ir      (clk_ir),
    .rst_il      (rst_il),
    .pulse_ih    (pulse_ih),
    .pulse_oh    (pulse_oh),
    .pend_oh     (pend_oh),
    .ovf_oh      (ovf_oh),
    .ovf_clr_ih  (ovf_clr_ih)
`ifdef PULSE_SPACER_DROP_CNT_EN
    ,
    .drop_cnt_oh (drop_cnt_oh)
`endif
  );

  typedef struct {
    int           edge_no;
    logic [N-1:0] pulse;
    logic [N-1:0] pend;
    logic [N-1:0] ovf;
    logic [N*8-1:0] drop;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_vec    = 0;
  int   n_bad    = 0;

  // Reference model state: queued events, cycles until the next emit is
  // allowed, edge of the last emitted pulse, sticky flag and drop tally.
  int m_pend [N];
  int m_cool [N];
  int m_last [N];
  int m_drop [N];
  bit m_ovf  [N];

  always @(posedge clk_ir) edge_cnt <= edge_cnt + 1;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_pend[c] = 0;
      m_cool[c] = 0;
      m_last[c] = -1000;
      m_drop[c] = 0;
      m_ovf[c]  = 1'b0;
    end
  endtask

  // Advance the model over the coming edge, using the inputs now applied.
  task automatic model_step();
    exp_t e;
    int   en;
    bit   emit;
    bit   drop;
    en        = edge_cnt + 1;
    e.edge_no = en;
    e.pulse   = '0;
    e.pend    = '0;
    e.ovf     = '0;
    e.drop    = '0;
    if (!rst_il) begin
      model_reset();
    end else begin
      for (int c = 0; c < N; c++) begin
        emit = 1'b0;
        drop = 1'b0;
        if (m_cool[c] == 0 && (m_pend[c] > 0 || pulse_ih[c])) begin
          emit = 1'b1;
          if (m_pend[c] > 0 && !pulse_ih[c]) m_pend[c]--;
          m_cool[c] = GAP;
          m_last[c] = en;
        end else begin
          if (m_cool[c] > 0) m_cool[c]--;
          if (pulse_ih[c]) begin
            if (m_pend[c] == PMAX) drop = 1'b1;
            else m_pend[c]++;
          end
        end
        m_ovf[c] = drop | (m_ovf[c] & ~ovf_clr_ih);
        if (ovf_clr_ih) m_drop[c] = drop ? 1 : 0;
        else if (drop && m_drop[c] < 255) m_drop[c]++;
        e.pulse[c] = emit;
        e.pend[c]  = (m_pend[c] > 0) || ((en - m_last[c]) <= GAP);
        e.ovf[c]   = m_ovf[c];
        e.drop[c*8 +: 8] = 8'(m_drop[c]);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [N-1:0] pin, input logic clr, input logic rst);
    @(posedge clk_ir);
    #1;
    pulse_ih   = pin;
    ovf_clr_ih = clr;
    rst_il     = rst;
    model_step();
  endtask

  // Assert reset mid-cycle. The expectation already queued for the next edge
  // is replaced, and the outputs must clear without waiting for a clock edge.
  task automatic async_reset();
    exp_t dummy;
    @(negedge clk_ir);
    #2;
    rst_il     = 1'b0;
    pulse_ih   = '0;
    ovf_clr_ih = 1'b0;
    dummy = exp_q.pop_back();
    model_step();
    #1;
    n_vec++;
    if (pulse_oh !== '0 || pend_oh !== '0 || ovf_oh !== '0) begin
      n_bad++;
      $display("FAIL async_reset: pulse=%b pend=%b ovf=%b, required all zero",
               pulse_oh, pend_oh, ovf_oh);
    end
  endtask

  // Monitor: compare every expectation whose edge has occurred.
  exp_t mon_e;
  always @(negedge clk_ir) begin
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (mon_e.edge_no != edge_cnt) begin
        n_bad++;
        $display("FAIL stale_entry: edge %0d, expected edge %0d", edge_cnt, mon_e.edge_no);
      end else if (pulse_oh !== mon_e.pulse || pend_oh !== mon_e.pend ||
                   ovf_oh !== mon_e.ovf) begin
        n_bad++;
        $display("FAIL outputs edge %0d: pulse=%b pend=%b ovf=%b, expected pulse=%b pend=%b ovf=%b",
                 edge_cnt, pulse_oh, pend_oh, ovf_oh, mon_e.pulse, mon_e.pend, mon_e.ovf);
      end
`ifdef PULSE_SPACER_DROP_CNT_EN
      n_vec++;
      if (drop_cnt_oh !== mon_e.drop) begin
        n_bad++;
        $display("FAIL drop_cnt edge %0d: got %h, expected %h",
                 edge_cnt, drop_cnt_oh, mon_e.drop);
      end
`endif
    end
  end

  initial begin
    int dens;
    logic [N-1:0] pin;
    model_reset();

    // Held in reset, then idle
    repeat (3) cycle('0, 1'b0, 1'b0);
    repeat (6) cycle('0, 1'b0, 1'b1);

    // Single pulse on channel 0
    cycle(2'b01, 1'b0, 1'b1);
    repeat (20) cycle('0, 1'b0, 1'b1);

    // Five back-to-back events on channel 0
    repeat (5) cycle(2'b01, 1'b0, 1'b1);
    repeat (30) cycle('0, 1'b0, 1'b1);

    // Saturation with a simultaneous issue+inject cycle and a clear racing a drop
    for (int i = 0; i < 12; i++) cycle(2'b01, (i == 11), 1'b1);
    repeat (60) cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b1, 1'b1);
    repeat (5) cycle('0, 1'b0, 1'b1);

    // Reset in the middle of a channel-1 backlog
    repeat (4) cycle(2'b10, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    async_reset();
    repeat (2) cycle('0, 1'b0, 1'b0);
    repeat (30) cycle('0, 1'b0, 1'b1);

    // Randomized traffic with varying density, rare clears and resets
    dens = 30;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) dens = $urandom_range(5, 95);
      if (k % 1000 == 500) begin
        async_reset();
        cycle('0, 1'b0, 1'b0);
      end
      for (int c = 0; c < N; c++) pin[c] = ($urandom_range(0, 99) < dens);
      cycle(pin, ($urandom_range(0, 63) == 0), 1'b1);
    end

    repeat (3) cycle('0, 1'b0, 1'b1);
    @(negedge clk_ir);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_pulse_spacer
